pc_next_unit: RTL and testbench
===============================

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, address loaded into pc at reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port stall  input  1  hold pc and fetch_count this cycle.
REQ-005 SHALL have port halt  input  1  request permanent stop until reset.
REQ-006 SHALL have port branch_taken  input  1  redirect to branch target.
REQ-007 SHALL have port signimm  input  32  sign-extended branch word offset.
REQ-008 SHALL have port jump  input  1  redirect to jump target.
REQ-009 SHALL have port jidx  input  26  jump instruction index field.
REQ-010 SHALL have port pc  output  32  current fetch address.
REQ-011 SHALL have port pcplus4  output  32  pc + 4, combinational.
REQ-012 SHALL have port fetch_valid  output  1  pc holds a fetchable address this cycle.
REQ-013 SHALL have port fetch_count  output  16  number of pc advances since reset.
REQ-014 SHALL have port halted  output  1  high in HALT state.

Function
REQ-015 SHALL implement states BOOT, RUN, HALT; BOOT -> RUN unconditionally after one cycle; RUN -> HALT when halt=1; HALT exits only via reset.
REQ-016 SHALL drive fetch_valid=1 only in RUN; halted=1 only in HALT.
REQ-017 SHALL compute pcplus4 = pc + 32'd4, modulo 2^32.
REQ-018 SHALL compute branch target = pcplus4 + {signimm[29:0], 2'b00}, modulo 2^32; signimm[31:30] discarded.
REQ-019 SHALL compute jump target = {pcplus4[31:28], jidx, 2'b00}.
REQ-020 SHALL, in RUN, select next pc by priority: halt (hold) > stall (hold) > jump > branch_taken > pcplus4.
REQ-021 SHALL increment fetch_count by 1 on every RUN cycle in which pc is updated (jump, branch or sequential); wrap 16'hFFFF -> 16'h0000.
REQ-022 SHALL hold pc and fetch_count in BOOT and HALT regardless of stall, jump, branch_taken.
REQ-023 SHALL ignore halt in BOOT; halt sampled first in RUN.
REQ-024 SHALL, with jump and branch_taken both high, take jump target.
REQ-025 SHALL, with halt and jump both high in RUN, enter HALT with pc unchanged.
REQ-026 SHALL have latency one cycle from select inputs to new pc; outputs pcplus4 and targets combinational from pc.

Reset
REQ-027 SHALL on reset=1 at a clock edge set pc=RESET_VECTOR, fetch_count=0, state=BOOT, regardless of state or other inputs, including mid-HALT.
REQ-028 SHALL give post-reset outputs: fetch_valid=0, halted=0, pcplus4=RESET_VECTOR+4.

Structure
REQ-029 SHALL place state enum type (BOOT, RUN, HALT) and constant PC_INCR=32'd4 in shared package cpu_pkg.
REQ-030 SHALL instantiate one sub-module, branch_target_gen: combinational shift-by-2 plus 32-bit add producing branch target from pcplus4 and signimm.
REQ-031 SHALL keep all sequential state (pc, fetch_count, state) in one clocked process.

Verification
REQ-032 Reset with RESET_VECTOR=32'h0040_0000, then 3 idle cycles -> pc 0x400000 (BOOT), 0x400000 (RUN), 0x400004, 0x400008; fetch_count 0,0,1,2.
REQ-033 pc=0x0000_1000, branch_taken=1, signimm=32'hFFFF_FFFE -> next pc=0x0000_0FFC; signimm=32'h0000_0003 -> next pc=0x0000_1010.
REQ-034 pc=0x8000_0010, jump=1, branch_taken=1, jidx=26'h000_0040 -> next pc=0x8000_0100.
REQ-035 pc=0xFFFF_FFFC sequential -> next pc=0x0000_0000; fetch_count=16'hFFFF advancing -> 16'h0000.
REQ-036 stall=1 for 3 cycles at pc=0x20 -> pc and fetch_count constant; halt=1 with jump=1 -> halted=1, pc=0x20 held through 10 cycles; reset -> BOOT, pc=RESET_VECTOR.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: fetch-control state encoding and the PC increment.
// Imported by the fetch-stage next-PC logic and its helpers.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/branch_target_gen.sv
// Branch target adder: pcplus4 + (signimm << 2), modulo 2^32.
// Ports: pcplus4, signimm (word offset) in; target out.
module branch_target_gen (
    input  logic [31:0] pcplus4,
    input  logic [31:0] signimm,
    output logic [31:0] target
);

    // The shift drops signimm[31:30], which is the intended behaviour.
    assign target = pcplus4 + (signimm << 2);

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC selection and fetch bookkeeping with a BOOT/RUN/HALT control FSM.
// Ports: clk, reset (sync, high), stall, halt, branch_taken, signimm, jump,
//        jidx in; pc, pcplus4, fetch_valid, fetch_count, halted out.
module pc_next_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch_taken,
    input  logic [31:0] signimm,
    input  logic        jump,
    input  logic [25:0] jidx,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        fetch_valid,
    output logic [15:0] fetch_count,
    output logic        halted
);

    state_t      state;
    state_t      state_n;
    logic [31:0] pc_n;
    logic [15:0] count_n;
    logic [31:0] btarget;
    logic [31:0] jtarget;

    assign pcplus4 = pc + PC_INCR;
    assign jtarget = {pcplus4[31:28], jidx, 2'b00};

    branch_target_gen u_btg (
        .pcplus4 (pcplus4),
        .signimm (signimm),
        .target  (btarget)
    );

    always_comb begin
        state_n = state;
        pc_n    = pc;
        count_n = fetch_count;
        unique case (state)
            BOOT: state_n = RUN;
            RUN: begin
                // halt wins over everything, stall over any redirect
                if (halt) begin
                    state_n = HALT;
                end else if (!stall) begin
                    count_n = fetch_count + 16'd1;
                    if (jump)
                        pc_n = jtarget;
                    else if (branch_taken)
                        pc_n = btarget;
                    else
                        pc_n = pcplus4;
                end
            end
            HALT: state_n = HALT;
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            fetch_count <= 16'd0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            fetch_count <= count_n;
        end
    end

    assign fetch_valid = (state == RUN);
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed vectors, corner sequences
// and randomized stimulus against a behavioural reference model.
module tb_pc_next_unit;

    localparam logic [31:0] RV = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        halt;
    logic        branch_taken;
    logic [31:0] signimm;
    logic        jump;
    logic [25:0] jidx;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        fetch_valid;
    logic [15:0] fetch_count;
    logic        halted;

    pc_next_unit #(.RESET_VECTOR(RV)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .halt         (halt),
        .branch_taken (branch_taken),
        .signimm      (signimm),
        .jump         (jump),
        .jidx         (jidx),
        .pc           (pc),
        .pcplus4      (pcplus4),
        .fetch_valid  (fetch_valid),
        .fetch_count  (fetch_count),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // reference model: 0 = boot, 1 = run, 2 = halt
    logic [31:0] m_pc;
    logic [15:0] m_cnt;
    int          m_st;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] start;
        logic        stall;
        logic        jump;
        logic        br;
        logic [31:0] simm;
        logic [25:0] jidx;
        logic [31:0] exp_pc;
        logic [15:0] inc;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] npc;
        logic [15:0] ncnt;
        int          nst;
        logic [31:0] p4;
        npc  = m_pc;
        ncnt = m_cnt;
        nst  = m_st;
        p4   = m_pc + 32'd4;
        if (reset) begin
            npc  = RV;
            ncnt = 16'd0;
            nst  = 0;
        end else if (m_st == 0) begin
            nst = 1;
        end else if (m_st == 1) begin
            if (halt) begin
                nst = 2;
            end else if (!stall) begin
                ncnt = m_cnt + 16'd1;
                if (jump)
                    npc = {p4[31:28], jidx, 2'b00};
                else if (branch_taken)
                    npc = p4 + signimm * 32'd4;
                else
                    npc = p4;
            end
        end
        @(posedge clk);
        #1;
        m_pc  = npc;
        m_cnt = ncnt;
        m_st  = nst;
    endtask

    task automatic idle();
        reset        = 1'b0;
        stall        = 1'b0;
        halt         = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        signimm      = 32'd0;
        jidx         = 26'd0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".pcplus4"}, pcplus4, m_pc + 32'd4);
        chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, (m_st == 1) ? 32'd1 : 32'd0);
        chk({tag, ".halted"}, {31'd0, halted}, (m_st == 2) ? 32'd1 : 32'd0);
        chk({tag, ".fetch_count"}, {16'd0, fetch_count}, {16'd0, m_cnt});
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // redirect to an aligned address via a taken branch
    task automatic go_to(input logic [31:0] target);
        idle();
        branch_taken = 1'b1;
        signimm      = (target - m_pc - 32'd4) >> 2;
        tick();
        idle();
        chk("goto.pc", pc, target);
    endtask

    initial begin
        logic [15:0] c0;
        m_pc  = 32'd0;
        m_cnt = 16'd0;
        m_st  = 0;

        tbl[0] = '{32'h0000_1000, 0, 0, 1, 32'hFFFF_FFFE, 26'd0, 32'h0000_0FFC, 16'd1};
        tbl[1] = '{32'h0000_1000, 0, 0, 1, 32'h0000_0003, 26'd0, 32'h0000_1010, 16'd1};
        tbl[2] = '{32'h8000_0010, 0, 1, 1, 32'h0000_0100, 26'h000_0040, 32'h8000_0100, 16'd1};
        tbl[3] = '{32'hFFFF_FFFC, 0, 0, 0, 32'd0, 26'd0, 32'h0000_0000, 16'd1};
        tbl[4] = '{32'h0000_0020, 1, 1, 1, 32'd5, 26'h3FF_FFFF, 32'h0000_0020, 16'd0};
        tbl[5] = '{32'h0000_1000, 0, 0, 1, 32'hC000_0001, 26'd0, 32'h0000_1008, 16'd1};
        tbl[6] = '{32'hF000_0000, 0, 1, 0, 32'd0, 26'h3FF_FFFF, 32'hFFFF_FFFC, 16'd1};
        tbl[7] = '{32'hFFFF_FFFC, 0, 1, 0, 32'd0, 26'h000_0001, 32'h0000_0004, 16'd1};

        // reset and first idle cycles
        idle();
        reset = 1'b1;
        tick();
        chk("rst.pc", pc, 32'h0040_0000);
        chk("rst.pcplus4", pcplus4, 32'h0040_0004);
        chk("rst.fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst.halted", {31'd0, halted}, 32'd0);
        chk("rst.count", {16'd0, fetch_count}, 32'd0);
        reset = 1'b0;
        tick();
        chk("boot.pc", pc, 32'h0040_0000);
        chk("boot.fv", {31'd0, fetch_valid}, 32'd1);
        chk("boot.count", {16'd0, fetch_count}, 32'd0);
        tick();
        chk("seq1.pc", pc, 32'h0040_0004);
        chk("seq1.count", {16'd0, fetch_count}, 32'd1);
        tick();
        chk("seq2.pc", pc, 32'h0040_0008);
        chk("seq2.count", {16'd0, fetch_count}, 32'd2);

        // directed vectors
        foreach (tbl[i]) begin
            go_to(tbl[i].start);
            c0           = m_cnt;
            stall        = tbl[i].stall;
            jump         = tbl[i].jump;
            branch_taken = tbl[i].br;
            signimm      = tbl[i].simm;
            jidx         = tbl[i].jidx;
            tick();
            idle();
            chk($sformatf("vec%0d.pc", i), pc, tbl[i].exp_pc);
            chk($sformatf("vec%0d.count", i), {16'd0, fetch_count},
                {16'd0, c0 + tbl[i].inc});
        end

        // halt is ignored during BOOT
        do_reset();
        halt = 1'b1;
        tick();
        chk("bootHalt.fv", {31'd0, fetch_valid}, 32'd1);
        chk("bootHalt.halted", {31'd0, halted}, 32'd0);
        tick();
        chk("runHalt.halted", {31'd0, halted}, 32'd1);
        chk("runHalt.pc", pc, RV);

        // stall, then halt with jump, then reset out of HALT
        do_reset();
        tick();
        go_to(32'h0000_0020);
        c0 = m_cnt;
        for (int k = 0; k < 3; k++) begin
            stall        = 1'b1;
            jump         = 1'b1;
            jidx         = 26'h123_4567;
            tick();
            chk("stall.pc", pc, 32'h0000_0020);
            chk("stall.count", {16'd0, fetch_count}, {16'd0, c0});
        end
        idle();
        halt = 1'b1;
        jump = 1'b1;
        jidx = 26'h000_0100;
        tick();
        chk("halt.halted", {31'd0, halted}, 32'd1);
        chk("halt.fv", {31'd0, fetch_valid}, 32'd0);
        chk("halt.pc", pc, 32'h0000_0020);
        for (int k = 0; k < 10; k++) begin
            halt         = k[0];
            stall        = $urandom_range(0, 1);
            jump         = $urandom_range(0, 1);
            branch_taken = $urandom_range(0, 1);
            signimm      = $urandom;
            jidx         = $urandom;
            tick();
            chk("halted.pc", pc, 32'h0000_0020);
            chk("halted.count", {16'd0, fetch_count}, {16'd0, c0});
        end
        check_all("halted");
        do_reset();
        chk("unhalt.pc", pc, RV);
        chk("unhalt.halted", {31'd0, halted}, 32'd0);
        chk("unhalt.fv", {31'd0, fetch_valid}, 32'd0);

        // fetch_count wrap
        tick();
        for (int k = 0; k < 65535; k++) tick();
        chk("wrap.pre", {16'd0, fetch_count}, 32'h0000_FFFF);
        tick();
        chk("wrap.post", {16'd0, fetch_count}, 32'd0);

        // randomized run against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            reset        = ($urandom_range(0, 99) == 0);
            halt         = ($urandom_range(0, 63) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            jump         = ($urandom_range(0, 4) == 0);
            branch_taken = ($urandom_range(0, 2) == 0);
            signimm      = $urandom;
            jidx         = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
            end
            tick();
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
